// File: rtl/pong_pkg.sv
// Screen and paddle geometry shared by the paddle controller and the renderers.
// Also holds the paddle direction type and the button-pair decode.
package pong_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PADDLE_W  = 10;
  localparam int PADDLE_H  = 60;
  localparam int Y_MAX     = SCREEN_H - PADDLE_H;
  localparam int PADDLE1_X = 10;
  localparam int PADDLE2_X = 620;
  localparam int BALL_SIZE = 8;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  // Opposing keys cancel out so a player mashing both stays put.
  function automatic dir_e decode_dir(input logic up, input logic down);
    dir_e d;
    d = DIR_NONE;
    if (up && !down) d = DIR_UP;
    if (down && !up) d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce counter for one active-low key; o_pressed is active-high.
// A change is accepted after DB_LIMIT consecutive differing samples (2 + DB_LIMIT cycles from the pin).
module btn_debounce
  import pong_pkg::*;
#(
  parameter int DB_LIMIT = 250000,
  parameter int DB_W     = 18
) (
  input  logic clk_in,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_pressed
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            btn_sync;

  assign btn_sync = ~sync2_q;

  always_comb begin
    sync1_d = i_btn_n;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (btn_sync == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = ~state_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pressed = state_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Debounced keys drive two paddles whose positions update once per frame, on the edge after pixel (639,479).
// Holding one direction for ACCEL_FRAMES ticks switches from STEP_SLOW to STEP_FAST; positions clamp to [0, Y_MAX].
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int DB_LIMIT     = 250000,
  parameter int DB_W         = 18,
  parameter int STEP_SLOW    = 2,
  parameter int STEP_FAST    = 6,
  parameter int ACCEL_FRAMES = 15,
  parameter int Y_INIT       = 210
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic [9:0] o_x,
  input  logic [8:0] o_y,
  input  logic [3:0] i_btn_n,
  input  logic       i_freeze,
  output logic [8:0] pos_yBarra1,
  output logic [8:0] pos_yBarra2,
  output logic       o_frame_tick
);

  localparam logic [9:0] LAST_X   = 10'(SCREEN_W - 1);
  localparam logic [8:0] LAST_Y   = 9'(SCREEN_H - 1);
  localparam logic [4:0] HOLD_MAX = 5'(ACCEL_FRAMES);
  localparam logic [9:0] LIMIT_10 = 10'(Y_MAX);

  logic [3:0] pressed;
  logic       tick_d, tick_q;
  logic [8:0] pos [2];

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_debounce #(
      .DB_LIMIT(DB_LIMIT),
      .DB_W    (DB_W)
    ) u_db (
      .clk_in   (clk_in),
      .i_rst    (i_rst),
      .i_btn_n  (i_btn_n[b]),
      .o_pressed(pressed[b])
    );
  end

  // The tick pixel is decoded in the same cycle the positions load, so the
  // new values appear together with o_frame_tick.
  always_comb begin
    tick_d = (o_x == LAST_X) && (o_y == LAST_Y);
  end

  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  for (genvar p = 0; p < 2; p++) begin : g_paddle
    dir_e       dir, prev_dir_q, prev_dir_d;
    logic [4:0] hold_q, hold_d;
    logic [8:0] pos_q, pos_d;
    logic [9:0] step, pos_ext, sum;

    assign dir     = decode_dir(pressed[2*p], pressed[2*p+1]);
    assign step    = (hold_q == HOLD_MAX) ? 10'(STEP_FAST) : 10'(STEP_SLOW);
    assign pos_ext = {1'b0, pos_q};
    assign sum     = pos_ext + step;

    always_comb begin
      prev_dir_d = prev_dir_q;
      hold_d     = hold_q;
      pos_d      = pos_q;
      if (tick_d) begin
        prev_dir_d = dir;
        if (i_freeze || dir == DIR_NONE || dir != prev_dir_q) begin
          hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 5'd1;
        end
        if (!i_freeze) begin
          case (dir)
            DIR_UP:   pos_d = (pos_ext < step) ? 9'd0 : 9'(pos_ext - step);
            DIR_DOWN: pos_d = (sum > LIMIT_10) ? 9'(Y_MAX) : sum[8:0];
            default:  pos_d = pos_q;
          endcase
        end
      end
    end

    always_ff @(posedge clk_in or negedge i_rst) begin
      if (!i_rst) begin
        prev_dir_q <= DIR_NONE;
        hold_q     <= '0;
        pos_q      <= 9'(Y_INIT);
      end else begin
        prev_dir_q <= prev_dir_d;
        hold_q     <= hold_d;
        pos_q      <= pos_d;
      end
    end

    assign pos[p] = pos_q;
  end

  assign pos_yBarra1  = pos[0];
  assign pos_yBarra2  = pos[1];
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomized bench for paddle_ctrl: a frame-level reference model pushes expected positions per tick,
// a monitor pops them whenever the DUT shows o_frame_tick.
module tb_paddle_ctrl;

  localparam int DBL   = 16;
  localparam int DBW   = 5;
  localparam int SLOW  = 2;
  localparam int FAST  = 6;
  localparam int ACCEL = 15;
  localparam int YINIT = 210;
  localparam int YLIM  = 420;
  localparam int HLEN  = DBL + 2;

  logic       clk_in   = 1'b0;
  logic       i_rst    = 1'b1;
  logic [9:0] o_x      = 10'd0;
  logic [8:0] o_y      = 9'd0;
  logic [3:0] i_btn_n  = 4'hF;
  logic       i_freeze = 1'b0;
  logic [8:0] pos1, pos2;
  logic       tick;

  always #5 clk_in = ~clk_in;

  paddle_ctrl #(
    .DB_LIMIT    (DBL),
    .DB_W        (DBW),
    .STEP_SLOW   (SLOW),
    .STEP_FAST   (FAST),
    .ACCEL_FRAMES(ACCEL),
    .Y_INIT      (YINIT)
  ) dut (
    .clk_in      (clk_in),
    .i_rst       (i_rst),
    .o_x         (o_x),
    .o_y         (o_y),
    .i_btn_n     (i_btn_n),
    .i_freeze    (i_freeze),
    .pos_yBarra1 (pos1),
    .pos_yBarra2 (pos2),
    .o_frame_tick(tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int p1;
    int p2;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a key counts as pressed once its pin has read the same
  // level for DBL consecutive clocks, seen two clocks late; paddle speed follows
  // the length of the current streak of same-direction, unfrozen ticks.
  int   m_pos    [2];
  int   m_streak [2];
  int   m_prev   [2];
  bit   m_deb    [4];
  bit   hist     [4][HLEN];
  int   m_dir, m_step, m_np;
  bit   m_same;
  exp_t m_e;

  always @(posedge clk_in) begin
    if (!i_rst) begin
      for (int p = 0; p < 2; p++) begin
        m_pos[p] = YINIT; m_streak[p] = 0; m_prev[p] = 0;
      end
      for (int b = 0; b < 4; b++) begin
        m_deb[b] = 1'b0;
        for (int i = 0; i < HLEN; i++) hist[b][i] = 1'b0;
      end
    end else begin
      if (o_x == 10'd639 && o_y == 9'd479) begin
        for (int p = 0; p < 2; p++) begin
          m_dir = 0;
          if (m_deb[2*p] && !m_deb[2*p+1]) m_dir = -1;
          if (m_deb[2*p+1] && !m_deb[2*p]) m_dir = 1;
          m_step = (m_streak[p] > ACCEL) ? FAST : SLOW;
          if (m_dir == 0) m_streak[p] = 0;
          else if (m_dir == m_prev[p] && !i_freeze) m_streak[p]++;
          else m_streak[p] = 1;
          m_prev[p] = m_dir;
          if (!i_freeze) begin
            m_np = m_pos[p] + m_dir * m_step;
            if (m_np < 0) m_np = 0;
            if (m_np > YLIM) m_np = YLIM;
            m_pos[p] = m_np;
          end
        end
        m_e.p1 = m_pos[0];
        m_e.p2 = m_pos[1];
        exp_q.push_back(m_e);
      end
      for (int b = 0; b < 4; b++) begin
        for (int i = HLEN - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = ~i_btn_n[b];
        m_same = 1'b1;
        for (int i = 2; i < HLEN; i++) if (hist[b][i] != hist[b][2]) m_same = 1'b0;
        if (m_same) m_deb[b] = hist[b][2];
      end
    end
  end

  // Monitor: every expected tick must show up exactly one cycle later.
  exp_t mon_e;
  always @(negedge clk_in) begin
    if (i_rst && (tick || exp_q.size() > 0)) begin
      check("tick_pulse", int'(tick), (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        if (tick) begin
          check("pos_yBarra1", int'(pos1), mon_e.p1);
          check("pos_yBarra2", int'(pos2), mon_e.p2);
        end
      end
    end
  end

  task automatic rand_pixel();
    o_x = 10'($urandom_range(0, 639));
    o_y = 9'($urandom_range(0, 479));
    case ($urandom_range(0, 7))
      0: begin o_x = 10'd639; o_y = 9'($urandom_range(0, 478)); end
      1: begin o_x = 10'($urandom_range(0, 638)); o_y = 9'd479; end
      default: ;
    endcase
    if (o_x == 10'd639 && o_y == 9'd479) o_y = 9'd478;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      rand_pixel();
    end
  endtask

  task automatic tick_px();
    @(negedge clk_in);
    o_x = 10'd639;
    o_y = 9'd479;
  endtask

  task automatic frame(input int n);
    idle(n);
    tick_px();
  endtask

  int bit_sel;

  initial begin
    #1 i_rst = 1'b0;
    #1;
    check("reset_pos1", int'(pos1), YINIT);
    check("reset_pos2", int'(pos2), YINIT);
    check("reset_tick", int'(tick), 0);
    idle(3);
    i_rst = 1'b1;

    // Idle frames, then down1 held long enough to accelerate and pin at the bottom.
    frame(20); frame(20); idle(3);
    i_btn_n[1] = 1'b0;
    repeat (60) frame(25);
    i_btn_n[1] = 1'b1;
    frame(25);

    // up2 held until pinned at the top.
    i_btn_n[2] = 1'b0;
    repeat (60) frame(25);
    i_btn_n[2] = 1'b1;
    frame(25);

    // Short glitches on up1, the longest just one sample short of acceptance.
    i_btn_n[0] = 1'b0; idle(10); i_btn_n[0] = 1'b1;
    frame(30);
    i_btn_n[0] = 1'b0; idle(DBL - 1); i_btn_n[0] = 1'b1;
    frame(30); frame(30);

    // Both paddle-1 keys cancel, then releasing down1 leaves a slow climb.
    i_btn_n[1:0] = 2'b00;
    repeat (5) frame(25);
    i_btn_n[1] = 1'b1;
    repeat (4) frame(25);
    i_btn_n[0] = 1'b1;
    frame(25);

    // Freeze while holding down1, then reset mid-hold.
    i_btn_n[1] = 1'b0;
    repeat (3) frame(25);
    i_freeze = 1'b1;
    repeat (4) frame(25);
    idle(3);
    #2 i_rst = 1'b0;
    #1;
    check("async_reset_pos1", int'(pos1), YINIT);
    check("async_reset_pos2", int'(pos2), YINIT);
    check("async_reset_tick", int'(tick), 0);
    idle(2);
    i_rst = 1'b1;
    i_freeze = 1'b0;
    repeat (3) frame(25);
    i_btn_n[1] = 1'b1;

    // Random phase: key changes, glitches, freeze and irregular tick spacing.
    repeat (800) begin
      case ($urandom_range(0, 5))
        0: begin
          bit_sel = $urandom_range(0, 3);
          i_btn_n[bit_sel] = ~i_btn_n[bit_sel];
        end
        1: begin
          bit_sel = $urandom_range(0, 3);
          i_btn_n[bit_sel] = ~i_btn_n[bit_sel];
          idle($urandom_range(1, DBL + 4));
          i_btn_n[bit_sel] = ~i_btn_n[bit_sel];
        end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) i_freeze = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 30));
      if ($urandom_range(0, 2) != 0) tick_px();
    end

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected the test to finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Reads the four player push-buttons, debounces them and produces the vertical positions of both paddles, `pos_yBarra1` and `pos_yBarra2`. The ball renderer and the paddle renderer consume these positions. Positions change only at the end of each frame, so a frame never shows a paddle that moved mid-scan. Holding a button for a while makes the paddle speed up.

## Interface
- `DB_LIMIT`, 250000: consecutive stable cycles required to accept a button change (10 ms at 25 MHz).
- `DB_W`, 18: width of the debounce counter. Must satisfy 2^DB_W > DB_LIMIT.
- `STEP_SLOW`, 2: pixels per frame before acceleration.
- `STEP_FAST`, 6: pixels per frame after acceleration.
- `ACCEL_FRAMES`, 15: consecutive held frames before switching to `STEP_FAST`.
- `Y_INIT`, 210: reset position of both paddles.
- `clk_in`  in  1  pixel clock; single clock domain.
- `i_rst`  in  1  asynchronous, active-low reset.
- `o_x`  in  10  current pixel x from the VGA timing generator.
- `o_y`  in  9  current pixel y from the VGA timing generator.
- `i_btn_n`  in  4  raw board keys, active-low, asynchronous. Bit 0 = up1, bit 1 = down1, bit 2 = up2, bit 3 = down2.
- `i_freeze`  in  1  holds both paddles in place (serve or pause).
- `pos_yBarra1`  out  9  top y of the left paddle.
- `pos_yBarra2`  out  9  top y of the right paddle.
- `o_frame_tick`  out  1  one-cycle pulse on the update cycle.

## Operation
- Synchronizer: each `i_btn_n` bit passes through 2 flops, reset to 1 (released). The synchronized value is then inverted to active-high.
- Debounce, one instance per bit:
  - The debounced state resets to 0 (released).
  - The counter clears whenever the synchronized input equals the debounced state.
  - Otherwise the counter increments.
  - When the count reaches `DB_LIMIT - 1`, the debounced state flips and the counter clears.
  - A glitch shorter than `DB_LIMIT` cycles is ignored.
- Direction per paddle:
  - up only → -1.
  - down only → +1.
  - both pressed or neither pressed → 0.
- Hold counter per paddle:
  - Width 5 bits, saturates at `ACCEL_FRAMES`.
  - Evaluated only on the frame tick.
  - Increments if the direction is nonzero and equals the previous tick's direction.
  - Clears to 0 if the direction is 0, the direction changed, or `i_freeze` = 1.
- Step size:
  - `STEP_FAST` if the hold counter equals `ACCEL_FRAMES`, otherwise `STEP_SLOW`.
  - The hold counter value used is the one from before the current tick's update.
- Position update on the frame tick, only when `i_freeze` = 0. Arithmetic is 10-bit unsigned.
  - Up: if pos < step, pos = 0; otherwise pos = pos - step.
  - Down: if pos + step > 420 (`Y_MAX` = 480 - `PADDLE_H`), pos = 420; otherwise pos = pos + step.
  - Direction 0: position unchanged.
- Reset (`i_rst` low, takes effect immediately):
  - `pos_yBarra1` = `pos_yBarra2` = `Y_INIT`.
  - `o_frame_tick` = 0.
  - All counters, debounced states and previous directions = 0.
  - Synchronizer flops = 1.
  - A reset in the middle of a debounce or hold sequence discards it entirely.

## Timing
- Frame tick condition: `o_x` = 639 and `o_y` = 479, decoded combinationally and registered.
  - `o_frame_tick` is high during the cycle after that pixel.
  - The new positions are registered on that same edge.
  - The ball logic samples at x = 638, so it always sees positions that are stable for the whole frame.
- Press latency: 2 synchronizer cycles plus `DB_LIMIT` cycles until the debounced state flips. The first movement follows at the next frame tick.
- Exactly one position update per frame, independent of how long a button is held within the frame.
- Releasing a button while the paddle sits at 0 or 420 has no effect. A paddle pinned at a limit does not wrap around.
- `i_freeze` is sampled on the tick cycle only.

## Structure
- Shared package `pong_pkg`: `SCREEN_W` = 640, `SCREEN_H` = 480, `PADDLE_W` = 10, `PADDLE_H` = 60, `Y_MAX` = 420, `PADDLE1_X` = 10, `PADDLE2_X` = 620, `BALL_SIZE` = 8. All of these are reused by the ball and paddle renderers.
- Sub-module `btn_debounce`: holds the synchronizer plus the debounce counter, parameterised by `DB_LIMIT` and `DB_W`. Instantiated 4 times.
- The top level holds the tick decode, the direction/hold logic and the clamped adders, once per paddle.

## Test plan
- Release reset with no keys pressed and run 2 frames → both positions stay 210; exactly 2 tick pulses, each 1 cycle wide, one cycle after (639,479). Simulate with `DB_LIMIT` = 16.
- Hold down1 steady → debounced state flips 18 cycles after the edge; positions over successive ticks are 212, 214, ...; after 15 held frames the step becomes 6; the paddle saturates at 420 and stays there.
- Hold up2 starting from position 3 → next tick gives 1, the following tick gives 0 (clamped), then 0 for every later tick.
- Apply a 10-cycle low pulse on `i_btn_n[0]` → no debounced change and no movement.
- Hold up1 and down1 together → no movement and the hold counter stays 0. Release down1 → the paddle moves with step 2.
- Assert `i_freeze` while holding down1, then pulse `i_rst` low mid-hold → no movement during freeze; both positions return to 210 immediately when reset asserts, with no clock edge required.
